// File: rtl/ct_ebiu_cawt_pkg.sv
// Shared defaults, drain state encoding and master-id decode for the EBIU CA write table.
package ct_ebiu_cawt_pkg;

  localparam int CAWT_ENTRY_NUM = 8;
  localparam int CAWT_ID_W      = 3;
  localparam int CAWT_ADDRW     = 40;
  localparam int CAWT_IDX_LSB   = 6;
  localparam int CAWT_IDX_W     = 8;
  localparam int CAWT_PIU_NUM   = 4;
  localparam int CAWT_MID_W     = 3;
  localparam int CAWT_SNB_NUM   = 2;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_BUSY = 2'd1,
    DRAIN_DONE = 2'd2
  } drain_state_e;

  // Low mid bits pick one PIU; the mid MSB broadcasts to every PIU. Caller keeps piu_num bits.
  function automatic logic [15:0] mid_to_sel(input logic [7:0] mid, input int mid_w,
                                             input int piu_num);
    logic [15:0] sel;
    int          piu_bits;
    piu_bits = $clog2(piu_num);
    sel = 16'd1 << (int'(mid) & ((1 << piu_bits) - 1));
    if (((mid >> (mid_w - 1)) & 8'd1) != 8'd0) begin
      sel = '1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ct_ebiu_cawt_slot.sv
// One CAWT slot: valid bit, gated index/mid storage, lookup compares and PIU select.
module ct_ebiu_cawt_slot
  import ct_ebiu_cawt_pkg::*;
#(
  parameter int IDX_W   = CAWT_IDX_W,
  parameter int MID_W   = CAWT_MID_W,
  parameter int PIU_NUM = CAWT_PIU_NUM,
  parameter int SNB_NUM = CAWT_SNB_NUM
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_icg_en,
  input  logic                       i_create,
  input  logic                       i_pop,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic [MID_W-1:0]           i_mid,
  input  logic [IDX_W-1:0]           i_rd_idx,
  input  logic [IDX_W-1:0]           i_wr_idx,
  input  logic [SNB_NUM*IDX_W-1:0]   i_snb_idx,
  output logic                       o_vld,
  output logic                       o_rd_hit,
  output logic                       o_wr_hit,
  output logic [SNB_NUM-1:0]         o_snb_hit,
  output logic [PIU_NUM-1:0]         o_sel
);

  logic             r_vld;
  logic [IDX_W-1:0] r_idx;
  logic [MID_W-1:0] r_mid;
  logic             w_gclk;
  logic [15:0]      w_sel_full;
  logic             w_sel_unused;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
    end else if (i_create) begin
      r_vld <= 1'b1;
    end else if (i_pop) begin
      r_vld <= 1'b0;
    end
  end

  // Reset rides on the local enable so the synchronous clear reaches the gated flops.
  gated_clk_cell u_icg (
    .clk_in             (i_clk),
    .global_en          (1'b1),
    .module_en          (i_icg_en),
    .local_en           (i_create | i_rst),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (1'b0),
    .clk_out            (w_gclk)
  );

  always_ff @(posedge w_gclk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_mid <= '0;
    end else begin
      r_idx <= i_idx;
      r_mid <= i_mid;
    end
  end

  assign o_vld    = r_vld;
  assign o_rd_hit = r_vld & (r_idx == i_rd_idx);
  assign o_wr_hit = r_vld & (r_idx == i_wr_idx);

  always_comb begin
    o_snb_hit = '0;
    for (int k = 0; k < SNB_NUM; k++) begin
      o_snb_hit[k] = r_vld & (i_snb_idx[k*IDX_W +: IDX_W] == r_idx);
    end
  end

  assign w_sel_full   = mid_to_sel(8'(r_mid), MID_W, PIU_NUM);
  assign w_sel_unused = ^w_sel_full;
  assign o_sel        = w_sel_full[PIU_NUM-1:0] & {PIU_NUM{r_vld}};

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate; enable is captured while the clock is low.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic w_clk_en_bf_latch;
  logic r_clk_en;

  assign w_clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  always_latch begin
    if (!clk_in) begin
      r_clk_en <= w_clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & r_clk_en;

endmodule

// File: rtl/ct_ebiu_cawt_table.sv
// CA write table: tracks outstanding non-cacheable writes from AW issue to B response.
//   state      | meaning
//   DRAIN_IDLE | creates allowed
//   DRAIN_BUSY | drain requested, creates blocked, waiting for empty
//   DRAIN_DONE | table empty, drain_ack held until drain_req drops
module ct_ebiu_cawt_table
  import ct_ebiu_cawt_pkg::*;
#(
  parameter int ENTRY_NUM = CAWT_ENTRY_NUM,
  parameter int ID_W      = CAWT_ID_W,
  parameter int ADDRW     = CAWT_ADDRW,
  parameter int IDX_LSB   = CAWT_IDX_LSB,
  parameter int IDX_W     = CAWT_IDX_W,
  parameter int PIU_NUM   = CAWT_PIU_NUM,
  parameter int MID_W     = CAWT_MID_W,
  parameter int SNB_NUM   = CAWT_SNB_NUM
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     create_vld,
  output logic                     create_rdy,
  input  logic [ADDRW-1:0]         create_addr,
  input  logic [MID_W-1:0]         create_mid,
  output logic [ID_W-1:0]          create_id,
  input  logic                     pop_vld,
  input  logic [ID_W-1:0]          pop_id,
  output logic                     pop_err,
  input  logic [ADDRW-1:0]         rd_addr,
  output logic                     rd_hit,
  input  logic [ADDRW-1:0]         wr_addr,
  output logic                     wr_hit,
  input  logic [SNB_NUM*IDX_W-1:0] snb_index,
  output logic [SNB_NUM-1:0]       snb_hit,
  output logic [PIU_NUM-1:0]       piu_pend,
  output logic [ENTRY_NUM-1:0]     vld_vec,
  output logic [ID_W:0]            cnt,
  output logic                     full,
  output logic                     empty,
  input  logic                     drain_req,
  output logic                     drain_ack
);

  logic [ENTRY_NUM-1:0]              w_vld;
  logic [ENTRY_NUM-1:0]              w_rd_hit_vec;
  logic [ENTRY_NUM-1:0]              w_wr_hit_vec;
  logic [ENTRY_NUM-1:0][SNB_NUM-1:0] w_snb_hit_mat;
  logic [ENTRY_NUM-1:0][PIU_NUM-1:0] w_sel;
  logic [ENTRY_NUM-1:0]              w_create_oh;
  logic [ENTRY_NUM-1:0]              w_pop_oh;
  logic [ID_W-1:0]                   w_create_id;
  logic                              w_fire;
  logic                              w_pop_legal;
  logic                              w_drain_idle;
  logic                              w_ciu_icg_en;
  logic                              w_addr_unused;
  logic [ID_W:0]                     r_cnt;
  logic                              r_pop_err;
  drain_state_e                      r_state;
  drain_state_e                      w_state_nxt;

  assign w_ciu_icg_en  = 1'b0;
  assign w_addr_unused = ^{create_addr, rd_addr, wr_addr};

  // Lowest free slot wins: scan from the top so the smallest index is written last.
  always_comb begin
    w_create_id = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!w_vld[i]) begin
        w_create_id = ID_W'(i);
      end
    end
  end

  assign full       = (r_cnt == (ID_W+1)'(ENTRY_NUM));
  assign empty      = (r_cnt == '0);
  assign create_rdy = ~full & w_drain_idle;
  assign create_id  = w_create_id;
  assign w_fire     = create_vld & create_rdy;

  // Out-of-range ids never match a slot, so they fall through to pop_err.
  always_comb begin
    w_create_oh = '0;
    w_pop_oh    = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_create_oh[i] = w_fire & (w_create_id == ID_W'(i));
      w_pop_oh[i]    = pop_vld & w_vld[i] & (pop_id == ID_W'(i));
    end
  end

  assign w_pop_legal = |w_pop_oh;

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_slot
    ct_ebiu_cawt_slot #(
      .IDX_W   (IDX_W),
      .MID_W   (MID_W),
      .PIU_NUM (PIU_NUM),
      .SNB_NUM (SNB_NUM)
    ) u_slot (
      .i_clk     (forever_cpuclk),
      .i_rst     (cpurst),
      .i_icg_en  (w_ciu_icg_en),
      .i_create  (w_create_oh[g]),
      .i_pop     (w_pop_oh[g]),
      .i_idx     (create_addr[IDX_LSB +: IDX_W]),
      .i_mid     (create_mid),
      .i_rd_idx  (rd_addr[IDX_LSB +: IDX_W]),
      .i_wr_idx  (wr_addr[IDX_LSB +: IDX_W]),
      .i_snb_idx (snb_index),
      .o_vld     (w_vld[g]),
      .o_rd_hit  (w_rd_hit_vec[g]),
      .o_wr_hit  (w_wr_hit_vec[g]),
      .o_snb_hit (w_snb_hit_mat[g]),
      .o_sel     (w_sel[g])
    );
  end

  assign vld_vec = w_vld;
  assign rd_hit  = |w_rd_hit_vec;
  assign wr_hit  = |w_wr_hit_vec;

  always_comb begin
    snb_hit  = '0;
    piu_pend = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      snb_hit  = snb_hit | w_snb_hit_mat[i];
      piu_pend = piu_pend | w_sel[i];
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_cnt     <= '0;
      r_pop_err <= 1'b0;
      r_state   <= DRAIN_IDLE;
    end else begin
      r_cnt     <= r_cnt + (ID_W+1)'(w_fire) - (ID_W+1)'(w_pop_legal);
      r_pop_err <= pop_vld & ~w_pop_legal;
      r_state   <= w_state_nxt;
    end
  end

  assign cnt     = r_cnt;
  assign pop_err = r_pop_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_idle = 1'b0;
    drain_ack    = 1'b0;
    case (r_state)
      DRAIN_IDLE: begin
        w_drain_idle = 1'b1;
        if (drain_req) w_state_nxt = DRAIN_BUSY;
      end
      DRAIN_BUSY: begin
        if (!drain_req)  w_state_nxt = DRAIN_IDLE;
        else if (empty)  w_state_nxt = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        drain_ack = 1'b1;
        if (!drain_req) w_state_nxt = DRAIN_IDLE;
      end
      default: w_state_nxt = DRAIN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ct_ebiu_cawt_table.sv
// Self-checking bench for ct_ebiu_cawt_table: directed scenarios plus random traffic vs a slot-array model.
module tb_ct_ebiu_cawt_table;

  localparam int EN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        create_vld;
  logic        create_rdy;
  logic [39:0] create_addr;
  logic [2:0]  create_mid;
  logic [2:0]  create_id;
  logic        pop_vld;
  logic [2:0]  pop_id;
  logic        pop_err;
  logic [39:0] rd_addr;
  logic        rd_hit;
  logic [39:0] wr_addr;
  logic        wr_hit;
  logic [15:0] snb_index;
  logic [1:0]  snb_hit;
  logic [3:0]  piu_pend;
  logic [7:0]  vld_vec;
  logic [3:0]  cnt;
  logic        full;
  logic        empty;
  logic        drain_req;
  logic        drain_ack;

  always #5 clk = ~clk;

  ct_ebiu_cawt_table dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .create_vld     (create_vld),
    .create_rdy     (create_rdy),
    .create_addr    (create_addr),
    .create_mid     (create_mid),
    .create_id      (create_id),
    .pop_vld        (pop_vld),
    .pop_id         (pop_id),
    .pop_err        (pop_err),
    .rd_addr        (rd_addr),
    .rd_hit         (rd_hit),
    .wr_addr        (wr_addr),
    .wr_hit         (wr_hit),
    .snb_index      (snb_index),
    .snb_hit        (snb_hit),
    .piu_pend       (piu_pend),
    .vld_vec        (vld_vec),
    .cnt            (cnt),
    .full           (full),
    .empty          (empty),
    .drain_req      (drain_req),
    .drain_ack      (drain_ack)
  );

  // Reference model: table as plain arrays; drain phase 0=idle, 1=draining, 2=done.
  bit         m_vld [EN];
  logic [7:0] m_idx [EN];
  logic [2:0] m_mid [EN];
  int         m_phase;
  bit         m_pop_err;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < EN; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < EN; i++) if (!m_vld[i]) return i;
    return -1;
  endfunction

  function automatic bit m_hit(input logic [7:0] ix);
    for (int i = 0; i < EN; i++) if (m_vld[i] && m_idx[i] == ix) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_piu();
    logic [3:0] p = '0;
    for (int i = 0; i < EN; i++) begin
      if (m_vld[i]) begin
        if (m_mid[i][2]) p = 4'hF;
        else p[m_mid[i][1:0]] = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < EN; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < EN; i++) begin
      m_vld[i] = 1'b0;
      m_idx[i] = '0;
      m_mid[i] = '0;
    end
    m_phase   = 0;
    m_pop_err = 1'b0;
  endtask

  task automatic model_step();
    int c, slot, nph;
    bit fire, legal;
    if (rst) begin
      m_clear();
      return;
    end
    c     = m_count();
    fire  = create_vld && (c < EN) && (m_phase == 0);
    slot  = m_lowest_free();
    legal = pop_vld && (int'(pop_id) < EN) && m_vld[pop_id];
    nph   = m_phase;
    if (!drain_req)                   nph = 0;
    else if (m_phase == 0)            nph = 1;
    else if (m_phase == 1 && c == 0)  nph = 2;
    if (legal) m_vld[pop_id] = 1'b0;
    if (fire) begin
      m_vld[slot] = 1'b1;
      m_idx[slot] = create_addr[13:6];
      m_mid[slot] = create_mid;
    end
    m_pop_err = pop_vld && !legal;
    m_phase   = nph;
  endtask

  task automatic check_all();
    int c = m_count();
    check("cnt", cnt, c);
    check("full", full, c == EN);
    check("empty", empty, c == 0);
    check("create_rdy", create_rdy, (c < EN) && (m_phase == 0));
    if (c < EN) check("create_id", create_id, m_lowest_free());
    check("vld_vec", vld_vec, m_vec());
    check("rd_hit", rd_hit, m_hit(rd_addr[13:6]));
    check("wr_hit", wr_hit, m_hit(wr_addr[13:6]));
    check("snb_hit", snb_hit, {m_hit(snb_index[15:8]), m_hit(snb_index[7:0])});
    check("piu_pend", piu_pend, m_piu());
    check("pop_err", pop_err, m_pop_err);
    check("drain_ack", drain_ack, m_phase == 2);
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [39:0] a;
    rst = 1'b1; create_vld = 1'b0; create_addr = '0; create_mid = '0;
    pop_vld = 1'b0; pop_id = '0; rd_addr = '0; wr_addr = '0; snb_index = '0; drain_req = 1'b0;
    m_clear();
    @(posedge clk);
    @(negedge clk);

    // Reset state
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_rdy", create_rdy, 1'b1);
    check("rst_cnt", cnt, 0);
    check("rst_piu", piu_pend, 0);
    tick();
    rst = 1'b0;

    // 1: fill
    for (int k = 0; k < EN; k++) begin
      create_vld = 1'b1; create_addr = 40'h40 * k; create_mid = 3'(k % 4);
      #1 check("t1_id", create_id, k);
      tick();
    end
    create_vld = 1'b0;
    #1;
    check("t1_full", full, 1'b1);
    check("t1_rdy", create_rdy, 1'b0);
    check("t1_piu", piu_pend, 4'hF);
    check("t1_cnt", cnt, 8);
    tick();

    // 3: pop and create together while full
    pop_vld = 1'b1; pop_id = 3'd3; create_vld = 1'b1; create_addr = 40'h7777_7FC0;
    #1 check("t3_rdy_blocked", create_rdy, 1'b0);
    tick();
    pop_vld = 1'b0;
    #1 check("t3_id", create_id, 3);
    tick();
    create_vld = 1'b0;
    #1 check("t3_cnt", cnt, 8);
    tick();

    for (int k = 0; k < EN; k++) begin
      pop_vld = 1'b1; pop_id = 3'(k);
      tick();
    end
    pop_vld = 1'b0;

    // 2: lookups
    create_vld = 1'b1; create_addr = 40'h1234_7680; create_mid = 3'd1;
    tick();
    create_vld = 1'b0;
    rd_addr = 40'h9_0000_3680;
    #1 check("t2_rd_hit", rd_hit, 1'b1);
    rd_addr = 40'h3640;
    #1 check("t2_rd_miss", rd_hit, 1'b0);
    snb_index = {8'hDA, 8'h00};
    #1 check("t2_snb", snb_hit, 2'b10);
    tick();
    pop_vld = 1'b1; pop_id = 3'd0;
    tick();

    // 4: illegal pop on empty table
    pop_id = 3'd5;
    tick();
    pop_vld = 1'b0;
    #1;
    check("t4_pop_err", pop_err, 1'b1);
    check("t4_cnt", cnt, 0);
    check("t4_vld", vld_vec, 0);
    tick();
    #1 check("t4_pop_err_clr", pop_err, 1'b0);

    // 5: drain handshake
    for (int k = 0; k < 2; k++) begin
      create_vld = 1'b1; create_addr = 40'h1000 + 40'h40 * k; create_mid = 3'(k);
      tick();
    end
    create_vld = 1'b0; drain_req = 1'b1;
    tick();
    #1 check("t5_rdy_blocked", create_rdy, 1'b0);
    create_vld = 1'b1;
    tick();
    create_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pop_vld = 1'b1; pop_id = 3'(k);
      tick();
    end
    pop_vld = 1'b0;
    #1 check("t5_ack_early", drain_ack, 1'b0);
    tick();
    #1 check("t5_ack", drain_ack, 1'b1);
    tick();
    drain_req = 1'b0;
    tick();
    #1 check("t5_rdy_back", create_rdy, 1'b1);

    // 6: broadcast then reset
    create_vld = 1'b1; create_addr = 40'h2_0000_0100; create_mid = 3'b100;
    tick();
    create_vld = 1'b0;
    #1 check("t6_piu", piu_pend, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_vld", vld_vec, 0);
    check("t6_cnt", cnt, 0);
    check("t6_piu_clr", piu_pend, 0);
    check("t6_ack", drain_ack, 1'b0);
    tick();

    // Random traffic with a small index pool so lookups collide
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      create_vld = ($urandom_range(0, 9) < 6);
      a = 40'({$urandom(), $urandom()});
      a[13:6] = 8'($urandom_range(0, 7) * 37 + 5);
      create_addr = a;
      create_mid  = 3'($urandom_range(0, 7));
      pop_vld     = ($urandom_range(0, 9) < 5);
      pop_id      = 3'($urandom_range(0, 7));
      a = 40'({$urandom(), $urandom()});
      a[13:6] = 8'($urandom_range(0, 7) * 37 + 5);
      rd_addr = a;
      a = 40'({$urandom(), $urandom()});
      a[13:6] = 8'($urandom_range(0, 7) * 37 + 5);
      wr_addr = a;
      snb_index = {8'($urandom_range(0, 7) * 37 + 5), 8'($urandom_range(0, 7) * 37 + 5)};
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
